// File: rtl/alu_byte_sequencer_if.sv
// Byte-stream handshake bundle for alu_byte_sequencer.
//   in_data/in_valid/in_ready    : input byte stream (producer -> sequencer)
//   out_data/out_valid/out_ready : result byte stream (sequencer -> consumer)
//   abort                        : synchronous transaction drop
// Handshake: a byte moves on a rising clock edge where valid and ready are
// both 1. A source holds data and valid stable until that edge. Ready may
// take any value while valid is 0.
// Modports: master = stream producer/consumer side, slave = sequencer side.
interface alu_byte_sequencer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       abort;

  modport master (
    output in_data, in_valid, out_ready, abort,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready, abort,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/alu_byte_sequencer.sv
// Byte-serial front end for a combinational 32-bit ALU.
// Collects an opcode byte and two MSB-first operands, presents them to the
// ALU, captures the result in one EXEC cycle and streams it out MSB first.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   bus          : handshake bundle (slave modport), see alu_byte_sequencer_if
//   alu_op/a/b   : registered opcode and operands driven to the ALU
//   alu_result   : combinational ALU result
//   busy         : 1 whenever the FSM is not waiting for an opcode
//   op_err       : last executed opcode was >= NUM_OPS
//   o_dbg_state  : current FSM state encoding (0 LOAD_OP .. 4 SEND)
module alu_byte_sequencer #(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 8,
  parameter int NUM_OPS = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_byte_sequencer_if.slave bus,
  output logic [OP_W-1:0]     alu_op,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  input  logic [DATA_W-1:0]   alu_result,
  output logic                busy,
  output logic                op_err,
  output logic [2:0]          o_dbg_state
);

  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int SH_W  = CNT_W + 4;

  typedef enum logic [2:0] {
    ST_LOAD_OP = 3'd0,
    ST_LOAD_A  = 3'd1,
    ST_LOAD_B  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_result;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [7:0]        r_out_data;

  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_last_byte;
  logic [SH_W-1:0]   w_sh_amt;
  logic [DATA_W-1:0] w_shifted;
  logic [7:0]        w_next_byte;

  assign w_in_xfer   = bus.in_valid & r_in_ready;
  assign w_out_xfer  = r_out_valid & bus.out_ready;
  assign w_last_byte = (r_cnt == CNT_W'(NB - 1));

  // Byte that follows the one currently presented: result shifted left by
  // (r_cnt+1) bytes, top byte taken. Only consumed when not on the last byte.
  assign w_sh_amt    = SH_W'({r_cnt, 3'b000}) + SH_W'(8);
  assign w_shifted   = r_result << w_sh_amt;
  assign w_next_byte = w_shifted[DATA_W-1 -: 8];

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign o_dbg_state   = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_LOAD_OP;
      r_cnt       <= '0;
      r_result    <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      busy        <= 1'b0;
      op_err      <= 1'b0;
    end else if (bus.abort) begin
      // Abort outranks any transfer presented in the same cycle.
      r_state     <= ST_LOAD_OP;
      r_cnt       <= '0;
      r_result    <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      busy        <= 1'b0;
      op_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD_OP: begin
          if (w_in_xfer) begin
            alu_op  <= OP_W'(bus.in_data);
            op_err  <= 1'b0;
            busy    <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_LOAD_A;
          end
        end
        ST_LOAD_A: begin
          if (w_in_xfer) begin
            alu_a <= (alu_a << 8) | DATA_W'(bus.in_data);
            if (w_last_byte) begin
              r_cnt   <= '0;
              r_state <= ST_LOAD_B;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_LOAD_B: begin
          if (w_in_xfer) begin
            alu_b <= (alu_b << 8) | DATA_W'(bus.in_data);
            if (w_last_byte) begin
              r_cnt      <= '0;
              r_in_ready <= 1'b0;
              r_state    <= ST_EXEC;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_EXEC: begin
          // Illegal opcodes still execute; only the flag records them.
          r_result    <= alu_result;
          op_err      <= (alu_op >= OP_W'(NUM_OPS));
          r_out_data  <= alu_result[DATA_W-1 -: 8];
          r_out_valid <= 1'b1;
          r_cnt       <= '0;
          r_state     <= ST_SEND;
        end
        ST_SEND: begin
          if (w_out_xfer) begin
            if (w_last_byte) begin
              r_cnt       <= '0;
              r_out_valid <= 1'b0;
              r_in_ready  <= 1'b1;
              busy        <= 1'b0;
              r_state     <= ST_LOAD_OP;
            end else begin
              r_cnt      <= r_cnt + 1'b1;
              r_out_data <= w_next_byte;
            end
          end
        end
        default: begin
          r_state     <= ST_LOAD_OP;
          r_cnt       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
